link_tx_credit_control: RTL and testbench

//  - Read-side controller for an output-port FIFO built on fifo_control_unit.
//  - Pops flits when the FIFO is non-empty and the downstream router has buffer

---
 rtl/link_tx_credit_control.sv | 143 ++++++++++++++
 tb/tb_link_tx_credit_control.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/link_tx_credit_control.sv
// Read-side link transmitter: pops the port FIFO while downstream credits remain
// and registers flits onto the channel. Optional flit counter via LINK_TX_FLIT_COUNTER_EN.
module link_tx_credit_control #(
  parameter int unsigned CHANNEL_WIDTH = 32,
  parameter int unsigned BUFFER_DEPTH  = 4
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        fifo_empty_din,
  input  logic [CHANNEL_WIDTH-1:0]                    fifo_data_din,
  input  logic                                        link_enable_din,
  input  logic                                        credit_return_din,
  output logic                                        fifo_read_strobe_dout,
  output logic [CHANNEL_WIDTH-1:0]                    channel_dout,
  output logic                                        channel_valid_dout,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]           credit_count_dout,
  output logic                                        credit_error_dout
`ifdef LINK_TX_FLIT_COUNTER_EN
  ,
  output logic [31:0]                                 flit_count_dout
`endif
);

  localparam int unsigned CREDIT_WIDTH = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(BUFFER_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE  = CREDIT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [CREDIT_WIDTH-1:0]   credit_count;
  logic [CREDIT_WIDTH-1:0]   credit_next;
  logic                      credit_error;
  logic                      error_next;
  logic [CHANNEL_WIDTH-1:0]  channel;
  logic [CHANNEL_WIDTH-1:0]  channel_next;
  logic                      channel_valid;
  logic                      valid_next;
  logic                      pending;
  logic                      has_credit;
  logic                      send;

  // State and datapath registers; reset drops any in-flight flit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      credit_count  <= CREDIT_FULL;
      credit_error  <= 1'b0;
      channel       <= '0;
      channel_valid <= 1'b0;
    end else begin
      state         <= state_next;
      credit_count  <= credit_next;
      credit_error  <= error_next;
      channel       <= channel_next;
      channel_valid <= valid_next;
    end
  end

  // Send decision, credit bookkeeping and next-state logic.
  always_comb begin
    pending      = ~fifo_empty_din & link_enable_din;
    has_credit   = (credit_count != '0);
    send         = pending & has_credit;
    state_next   = state;
    credit_next  = credit_count;
    error_next   = credit_error;
    channel_next = channel;
    valid_next   = 1'b0;

    if (send) begin
      channel_next = fifo_data_din;
      valid_next   = 1'b1;
    end

    // A return with no send at full count is a protocol error and saturates.
    unique case ({send, credit_return_din})
      2'b10: credit_next = credit_count - CREDIT_ONE;
      2'b01: begin
        if (credit_count == CREDIT_FULL) begin
          error_next = 1'b1;
        end else begin
          credit_next = credit_count + CREDIT_ONE;
        end
      end
      default: credit_next = credit_count;
    endcase

    unique case (state)
      IDLE: begin
        if (send) begin
          state_next = SEND;
        end else if (pending) begin
          state_next = STALL;
        end
      end
      SEND: begin
        if (send) begin
          state_next = SEND;
        end else if (pending) begin
          state_next = STALL;
        end else begin
          state_next = IDLE;
        end
      end
      STALL: begin
        if (send) begin
          state_next = SEND;
        end else if (!pending) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fifo_read_strobe_dout = send;
  assign channel_dout          = channel;
  assign channel_valid_dout    = channel_valid;
  assign credit_count_dout     = credit_count;
  assign credit_error_dout     = credit_error;

`ifdef LINK_TX_FLIT_COUNTER_EN
  logic [31:0] flit_count;

  // Free-running count of issued flits; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit_count <= '0;
    end else if (send) begin
      flit_count <= flit_count + 32'd1;
    end
  end

  assign flit_count_dout = flit_count;
`endif

endmodule

// File: tb/tb_link_tx_credit_control.sv
// Scoreboard bench for link_tx_credit_control: expected flits are queued at
// pop time and a negedge monitor checks them as the channel presents them.
module tb_link_tx_credit_control;

  localparam int unsigned CW = 32;

  logic          clk;
  logic          reset;
  logic          fifo_empty_din;
  logic [CW-1:0] fifo_data_din;
  logic          link_enable_din;
  logic          credit_return_din;
  logic          fifo_read_strobe_dout;
  logic [CW-1:0] channel_dout;
  logic          channel_valid_dout;
  logic [2:0]    credit_count_dout;
  logic          credit_error_dout;
`ifdef LINK_TX_FLIT_COUNTER_EN
  logic [31:0]   flit_count_dout;
`endif

  link_tx_credit_control #(.CHANNEL_WIDTH(CW), .BUFFER_DEPTH(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .fifo_empty_din        (fifo_empty_din),
    .fifo_data_din         (fifo_data_din),
    .link_enable_din       (link_enable_din),
    .credit_return_din     (credit_return_din),
    .fifo_read_strobe_dout (fifo_read_strobe_dout),
    .channel_dout          (channel_dout),
    .channel_valid_dout    (channel_valid_dout),
    .credit_count_dout     (credit_count_dout),
    .credit_error_dout     (credit_error_dout)
`ifdef LINK_TX_FLIT_COUNTER_EN
    ,
    .flit_count_dout       (flit_count_dout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [CW-1:0] exp_q[$];
  logic last_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid flit on the link must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && channel_valid_dout) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_flit: got %h expected none", channel_dout);
      end else begin
        check("flit_data", channel_dout, exp_q.pop_front());
      end
    end
  end

  // One cycle: drive inputs just after the edge, then check the visible state.
  task automatic tick(input string name, input logic empty, input logic [CW-1:0] data,
                      input logic en, input logic ret, input logic exp_strobe,
                      input int exp_cnt, input logic exp_err);
    @(posedge clk);
    #1;
    check({name, "_valid"}, 32'(channel_valid_dout), 32'(last_strobe));
    fifo_empty_din    = empty;
    fifo_data_din     = data;
    link_enable_din   = en;
    credit_return_din = ret;
    #1;
    check({name, "_strobe"}, 32'(fifo_read_strobe_dout), 32'(exp_strobe));
    check({name, "_count"}, 32'(credit_count_dout), 32'(exp_cnt));
    check({name, "_error"}, 32'(credit_error_dout), 32'(exp_err));
    if (exp_strobe) exp_q.push_back(data);
    last_strobe = exp_strobe;
  endtask

  localparam logic [CW-1:0] FA = 32'hA000_000A;
  localparam logic [CW-1:0] FB = 32'hB000_000B;
  localparam logic [CW-1:0] FC = 32'hC000_000C;
  localparam logic [CW-1:0] FD = 32'hD000_000D;
  localparam logic [CW-1:0] FE = 32'hE000_000E;
  localparam logic [CW-1:0] FF = 32'hF000_000F;

  initial begin
    reset             = 1'b1;
    fifo_empty_din    = 1'b1;
    fifo_data_din     = '0;
    link_enable_din   = 1'b1;
    credit_return_din = 1'b0;
    #12;
    reset = 1'b0;
    #1;
    check("rst_count", 32'(credit_count_dout), 32'd4);
    check("rst_valid", 32'(channel_valid_dout), 32'd0);
    check("rst_error", 32'(credit_error_dout), 32'd0);
    check("rst_strobe", 32'(fifo_read_strobe_dout), 32'd0);

    // Burst of A..F with no returns: four go out, then stall.
    tick("a", 0, FA, 1, 0, 1, 4, 0);
    tick("b", 0, FB, 1, 0, 1, 3, 0);
    tick("c", 0, FC, 1, 0, 1, 2, 0);
    tick("d", 0, FD, 1, 0, 1, 1, 0);
    tick("stall0", 0, FE, 1, 0, 0, 0, 0);
    tick("stall1", 0, FE, 1, 0, 0, 0, 0);

    // One return in stall: usable the following cycle only.
    tick("ret_e", 0, FE, 1, 1, 0, 0, 0);
    tick("e", 0, FE, 1, 0, 1, 1, 0);
    tick("f_stall", 0, FF, 1, 0, 0, 0, 0);

    // Empty FIFO, two returns; channel data must hold E.
    tick("refill0", 1, '0, 1, 1, 0, 0, 0);
    check("hold_data", channel_dout, FE);
    tick("refill1", 1, '0, 1, 1, 0, 1, 0);

    // Continuous stream with a return every cycle at count 2.
    for (int i = 0; i < 4; i++)
      tick($sformatf("stream%0d", i), 0, 32'h5000_0000 + 32'(i), 1, 1, 1, 2, 0);
    tick("stream_end", 1, '0, 1, 0, 0, 2, 0);

    // Link disable mid-burst stops pops the same cycle.
    tick("x", 0, 32'h1111_2222, 1, 0, 1, 2, 0);
    tick("dis0", 0, 32'h3333_4444, 0, 0, 0, 1, 0);
    tick("dis1", 0, 32'h3333_4444, 0, 0, 0, 1, 0);

    // Return credits to full, then one extra return raises the sticky error.
    tick("up1", 1, '0, 1, 1, 0, 1, 0);
    tick("up2", 1, '0, 1, 1, 0, 2, 0);
    tick("up3", 1, '0, 1, 1, 0, 3, 0);
    tick("over", 1, '0, 1, 1, 0, 4, 0);
    tick("err0", 1, '0, 1, 0, 0, 4, 1);
    tick("err1", 1, '0, 1, 0, 0, 4, 1);

    // Reset mid-burst at count 1 with a valid flit on the link.
    tick("p", 0, 32'h0000_0101, 1, 0, 1, 4, 1);
    tick("q", 0, 32'h0000_0202, 1, 0, 1, 3, 1);
    tick("r", 0, 32'h0000_0303, 1, 0, 1, 2, 1);
    @(posedge clk);
    #1;
    fifo_empty_din = 1'b1;
    check("mid_count", 32'(credit_count_dout), 32'd1);
    check("mid_valid", 32'(channel_valid_dout), 32'd1);
    check("mid_data", channel_dout, 32'h0000_0303);
    exp_q.delete();
    #1;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(channel_valid_dout), 32'd0);
    check("arst_count", 32'(credit_count_dout), 32'd4);
    check("arst_error", 32'(credit_error_dout), 32'd0);
    check("arst_data", channel_dout, 32'd0);
    last_strobe = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    tick("s", 0, 32'h0000_0404, 1, 0, 1, 4, 0);
    tick("post0", 1, '0, 1, 0, 0, 3, 0);
    tick("post1", 1, '0, 1, 0, 0, 3, 0);

    @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
